// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM.
// The HALT state is only reachable when MIPS_CTRL_ILLEGAL_TRAP_EN is defined.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic       mdr_en;
    logic       ab_en;
    logic       aluout_en;
    logic       reg_write;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_src_t    pc_src;
  } ctrl_word_t;

endpackage

// File: rtl/mips_ctrl_out_decode.sv
// Combinational Moore output decode: current state (+ zero in BRANCH) to control word.
module mips_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       zero,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_en     = 1'b1;
        ctrl.pc_en     = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        ctrl.ab_en     = 1'b1;
        ctrl.aluout_en = 1'b1;
        ctrl.alu_src_b = SRCB_IMM_SH;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.aluout_en = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord   = 1'b1;
        ctrl.mdr_en = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.aluout_en = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.pc_en     = zero;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src = PC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic, reset/run gating.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with a sticky illegal_op flag.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                pc_en,
  output logic                ir_en,
  output logic                mdr_en,
  output logic                ab_en,
  output logic                aluout_en,
  output logic                reg_write,
  output logic                mem_write,
  output logic                iord,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic [STATE_W-1:0]  state
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_op
`endif
);

  state_t     cur;
  ctrl_word_t dec;
  ctrl_word_t ctrl;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur <= S_FETCH;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      illegal_op <= 1'b0;
`endif
    end else if (run) begin
      case (cur)
        S_FETCH: cur <= S_DECODE;
        S_DECODE: begin
          if (opcode == OPCODE_W'(OP_RTYPE))
            cur <= S_EXEC;
          else if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW))
            cur <= S_MEMADR;
          else if (opcode == OPCODE_W'(OP_BEQ))
            cur <= S_BRANCH;
          else if (opcode == OPCODE_W'(OP_ADDI))
            cur <= S_ADDIEX;
          else if (opcode == OPCODE_W'(OP_J))
            cur <= S_JUMP;
          else begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            cur        <= S_HALT;
            illegal_op <= 1'b1;
`else
            // PC already advanced in FETCH, so dropping back makes this a NOP.
            cur <= S_FETCH;
`endif
          end
        end
        S_MEMADR: cur <= (opcode == OPCODE_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  cur <= S_MEMWB;
        S_EXEC:   cur <= S_ALUWB;
        S_ADDIEX: cur <= S_ADDIWB;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        S_HALT:   cur <= S_HALT;
`endif
        default:  cur <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_out_decode u_decode (
    .state (cur),
    .zero  (zero),
    .ctrl  (dec)
  );

  // Reset clears everything; a stall only suppresses strobes, selects stay stable.
  always_comb begin
    ctrl = dec;
    if (!reset) begin
      ctrl = '0;
    end else if (!run) begin
      ctrl.pc_en     = 1'b0;
      ctrl.ir_en     = 1'b0;
      ctrl.mdr_en    = 1'b0;
      ctrl.ab_en     = 1'b0;
      ctrl.aluout_en = 1'b0;
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign ir_en      = ctrl.ir_en;
  assign mdr_en     = ctrl.mdr_en;
  assign ab_en      = ctrl.ab_en;
  assign aluout_en  = ctrl.aluout_en;
  assign reg_write  = ctrl.reg_write;
  assign mem_write  = ctrl.mem_write;
  assign iord       = ctrl.iord;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign state      = STATE_W'(cur);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; honours MIPS_CTRL_ILLEGAL_TRAP_EN when defined.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic       mdr_en;
    logic       ab_en;
    logic       aluout_en;
    logic       reg_write;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } word_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b1;
  logic [5:0] opcode = 6'b100011;
  logic       zero = 1'b0;
  logic       pc_en, ir_en, mdr_en, ab_en, aluout_en, reg_write, mem_write;
  logic       iord, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  word_t       obs;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OPCODE_W(6), .STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .zero       (zero),
    .pc_en      (pc_en),
    .ir_en      (ir_en),
    .mdr_en     (mdr_en),
    .ab_en      (ab_en),
    .aluout_en  (aluout_en),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .iord       (iord),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .state      (state)
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  assign obs = '{pc_en, ir_en, mdr_en, ab_en, aluout_en, reg_write, mem_write,
                 iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output table written straight from the per-state list, then reset/stall gating.
  function automatic word_t exp_word(input int s, input logic z, input logic rst, input logic rn);
    word_t w = '0;
    case (s)
      0:  begin w.ir_en = 1; w.pc_en = 1; w.alu_src_b = 2'b01; end
      1:  begin w.ab_en = 1; w.aluout_en = 1; w.alu_src_b = 2'b11; end
      2:  begin w.aluout_en = 1; w.alu_src_a = 1; w.alu_src_b = 2'b10; end
      3:  begin w.iord = 1; w.mdr_en = 1; end
      4:  begin w.reg_write = 1; w.mem_to_reg = 1; end
      5:  begin w.iord = 1; w.mem_write = 1; end
      6:  begin w.aluout_en = 1; w.alu_src_a = 1; w.alu_op = 2'b10; end
      7:  begin w.reg_write = 1; w.reg_dst = 1; end
      8:  begin w.alu_src_a = 1; w.alu_op = 2'b01; w.pc_src = 2'b01; w.pc_en = z; end
      9:  begin w.aluout_en = 1; w.alu_src_a = 1; w.alu_src_b = 2'b10; end
      10: w.reg_write = 1;
      11: begin w.pc_src = 2'b10; w.pc_en = 1; end
      default: w = '0;
    endcase
    if (!rst) w = '0;
    else if (!rn) begin
      w.pc_en = 0; w.ir_en = 0; w.mdr_en = 0; w.ab_en = 0;
      w.aluout_en = 0; w.reg_write = 0; w.mem_write = 0;
    end
    return w;
  endfunction

  task automatic expect_now(input int s, input string tag);
    check($sformatf("%s state", tag), 32'(state), 32'(s));
    check($sformatf("%s ctrl", tag), 32'(obs), 32'(exp_word(s, zero, reset, run)));
  endtask

  task automatic step(input int s, input string tag);
    @(posedge clk);
    #1;
    expect_now(s, tag);
  endtask

  initial begin
    // Reset held for two edges with run=1
    #1;
    check("reset strobes pre-edge", 32'(obs), 32'h0);
    step(0, "reset e1");
    step(0, "reset e2");
    reset = 1'b1;
    #1;
    expect_now(0, "fetch after reset");

    // LW: 0,1,2,3,4,0
    opcode = 6'b100011;
    step(1, "lw decode");
    step(2, "lw memadr");
    step(3, "lw memrd");
    step(4, "lw memwb");
    step(0, "lw back");

    // BEQ taken and not taken
    opcode = 6'b000100;
    zero = 1'b1;
    step(1, "beq1 decode");
    step(8, "beq1 branch");
    check("beq taken pc_en", 32'(pc_en), 32'd1);
    step(0, "beq1 back");
    zero = 1'b0;
    step(1, "beq0 decode");
    step(8, "beq0 branch");
    check("beq not taken pc_en", 32'(pc_en), 32'd0);
    step(0, "beq0 back");

    // R-type with three stalled cycles in EXEC
    opcode = 6'b000000;
    step(1, "rtype decode");
    step(6, "rtype exec");
    run = 1'b0;
    #1;
    expect_now(6, "rtype stall0");
    for (int i = 0; i < 3; i++) step(6, $sformatf("rtype stall%0d", i + 1));
    check("stall aluout_en", 32'(aluout_en), 32'd0);
    run = 1'b1;
    #1;
    expect_now(6, "rtype resume");
    check("resume aluout_en", 32'(aluout_en), 32'd1);
    step(7, "rtype aluwb");
    step(0, "rtype back");

    // SW aborted by reset in MEMADR
    opcode = 6'b101011;
    step(1, "sw decode");
    step(2, "sw memadr");
    reset = 1'b0;
    #1;
    expect_now(2, "sw reset comb");
    step(0, "sw reset edge");
    check("sw mem_write", 32'(mem_write), 32'd0);
    reset = 1'b1;
    #1;
    expect_now(0, "sw fetch");

    // ADDI, then J with zero high to show zero is ignored outside BRANCH
    opcode = 6'b001000;
    step(1, "addi decode");
    step(9, "addi ex");
    step(10, "addi wb");
    step(0, "addi back");
    opcode = 6'b000010;
    zero = 1'b1;
    step(1, "j decode");
    step(11, "j jump");
    step(0, "j back");
    zero = 1'b0;

    // Illegal opcode
    opcode = 6'b111111;
    step(1, "ill decode");
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    step(12, "ill halt");
    check("illegal_op set", 32'(illegal_op), 32'd1);
    opcode = 6'b000000;
    step(12, "ill halt hold1");
    step(12, "ill halt hold2");
    check("illegal_op sticky", 32'(illegal_op), 32'd1);
    reset = 1'b0;
    step(0, "ill reset");
    check("illegal_op cleared", 32'(illegal_op), 32'd0);
    reset = 1'b1;
    #1;
    expect_now(0, "ill fetch");
`else
    step(0, "ill nop back");
    opcode = 6'b000000;
    step(1, "after ill decode");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
